// File: rtl/lstm_gate_feeder_if.sv
// lstm_gate_feeder_if: start, operand-memory, gate-operand and activation signals of one gate feeder
interface lstm_gate_feeder_if #(
  parameter int WIDTH = 24,
  parameter int AW = 6
);
  logic i_start;
  logic [AW-1:0] o_x_addr;
  logic [AW-1:0] o_h_addr;
  logic o_rd_en;
  logic [WIDTH-1:0] i_x_rd;
  logic [WIDTH-1:0] i_w_rd;
  logic [WIDTH-1:0] i_h_rd;
  logic [WIDTH-1:0] i_u_rd;
  logic [WIDTH-1:0] o_x;
  logic [WIDTH-1:0] o_w;
  logic [WIDTH-1:0] o_h;
  logic [WIDTH-1:0] o_u;
  logic o_acc_x;
  logic o_acc_h;
  logic [WIDTH-1:0] i_act;
  logic [WIDTH-1:0] o_act;
  logic o_valid;
  logic o_busy;
  modport master (
    input i_start, i_x_rd, i_w_rd, i_h_rd, i_u_rd, i_act,
    output o_x_addr, o_h_addr, o_rd_en, o_x, o_w, o_h, o_u, o_acc_x, o_acc_h, o_act, o_valid, o_busy
  );
  modport slave (
    output i_start, i_x_rd, i_w_rd, i_h_rd, i_u_rd, i_act,
    input o_x_addr, o_h_addr, o_rd_en, o_x, o_w, o_h, o_u, o_acc_x, o_acc_h, o_act, o_valid, o_busy
  );
endinterface

// File: rtl/lstm_gate_feeder.sv
// lstm_gate_feeder: walks x/W and h/U memories into one LSTM gate's MACs and captures its activation
module lstm_gate_feeder #(
  parameter int WIDTH = 24,
  parameter int FRAC = 20,
  parameter int NX = 53,
  parameter int NH = 53,
  parameter int AW = 6
) (
  input logic clk,
  input logic rst,
  lstm_gate_feeder_if.master bus
);
  localparam int L = (NX > NH) ? NX : NH;
  localparam logic [AW-1:0] LAST = AW'(L - 1);
  localparam logic [AW-1:0] XMAX = AW'(NX - 1);
  localparam logic [AW-1:0] HMAX = AW'(NH - 1);
  if (FRAC >= WIDTH || L > (1 << AW)) begin : g_bad_cfg
    $error("lstm_gate_feeder: FRAC must be below WIDTH and 2**AW must cover max(NX,NH)");
  end
  typedef enum logic [2:0] {IDLE, RUN, FLUSH, SETTLE, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, idx_q, idx_d, x_addr_q, x_addr_d, h_addr_q, h_addr_d;
  logic fd_q, fd_d, rdy_q, rdy_d, go, x_on, h_on;
  logic [WIDTH-1:0] act_q, act_d;
  always_comb begin
    go = bus.i_start && (state_q == IDLE || state_q == CAPTURE);
    state_d = go ? RUN
            : state_q == RUN ? (cnt_q == LAST ? FLUSH : RUN)
            : state_q == FLUSH ? SETTLE
            : state_q == SETTLE ? CAPTURE
            : IDLE;
    cnt_d = go ? '0 : (state_q == RUN && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
    x_addr_d = state_d == RUN ? (cnt_d > XMAX ? XMAX : cnt_d) : x_addr_q;
    h_addr_d = state_d == RUN ? (cnt_d > HMAX ? HMAX : cnt_d) : h_addr_q;
    fd_d = state_q == RUN;
    idx_d = state_q == RUN ? cnt_q : idx_q;
    act_d = state_q == SETTLE ? bus.i_act : act_q;
    rdy_d = 1'b1;
    x_on = fd_q && idx_q <= XMAX;
    h_on = fd_q && idx_q <= HMAX;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      x_addr_q <= '0;
      h_addr_q <= '0;
      fd_q <= 1'b0;
      rdy_q <= 1'b0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      x_addr_q <= x_addr_d;
      h_addr_q <= h_addr_d;
      fd_q <= fd_d;
      rdy_q <= rdy_d;
      act_q <= act_d;
    end
  end
  assign bus.o_rd_en = state_q == RUN;
  assign bus.o_busy = state_q == RUN || state_q == FLUSH || state_q == SETTLE;
  assign bus.o_valid = state_q == CAPTURE;
  assign bus.o_act = act_q;
  assign bus.o_x_addr = x_addr_q;
  assign bus.o_h_addr = h_addr_q;
  assign bus.o_x = x_on ? bus.i_x_rd : '0;
  assign bus.o_w = x_on ? bus.i_w_rd : '0;
  assign bus.o_h = h_on ? bus.i_h_rd : '0;
  assign bus.o_u = h_on ? bus.i_u_rd : '0;
  assign bus.o_acc_x = fd_q ? idx_q != '0 : rdy_q;
  assign bus.o_acc_h = fd_q ? idx_q != '0 : rdy_q;
endmodule
